// File: rtl/pool_stream.sv
// pool_stream: streaming multi-channel 2-D max/average pooling engine.
// Raster-order pixels come in (all lanes in parallel), a POOL_SIZE-row line
// buffer holds the rows still needed, and each window is evaluated on the
// beat that delivers its bottom-right pixel. A single output register with
// in_ready = !out_valid || out_ready gives full throughput without bubbles.
module pool_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 4,
  parameter int IMG_WIDTH   = 3,
  parameter int IMG_HEIGHT  = 3,
  parameter int POOL_SIZE   = 2,
  parameter int POOL_STRIDE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           frame_done
);

  localparam int OUT_WIDTH  = (IMG_WIDTH - POOL_SIZE) / POOL_STRIDE + 1;
  localparam int OUT_HEIGHT = (IMG_HEIGHT - POOL_SIZE) / POOL_STRIDE + 1;
  localparam int LAST_ROW   = (OUT_HEIGHT - 1) * POOL_STRIDE + POOL_SIZE - 1;
  localparam int LAST_COL   = (OUT_WIDTH - 1) * POOL_STRIDE + POOL_SIZE - 1;
  localparam int SHIFT      = 2 * $clog2(POOL_SIZE);
  localparam int SUM_W      = DATA_WIDTH + SHIFT;
  localparam int WIN        = POOL_SIZE * POOL_SIZE;
  localparam int DEPTH      = POOL_SIZE * IMG_WIDTH;
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PIX_W      = CHANNELS * DATA_WIDTH;

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              mode_reg;
  logic              out_valid_reg;
  logic [PIX_W-1:0]  out_data_reg;
  logic              out_last_reg;
  logic              frame_done_reg;

  logic [PIX_W-1:0]  line_mem [DEPTH];
  logic [PIX_W-1:0]  win [WIN];
  logic [PIX_W-1:0]  result;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              fire;
  logic              last_pos;
  logic              first_pix;
  logic              mode_eff;

  assign in_ready   = !out_valid_reg || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_last   = out_last_reg;
  assign frame_done = frame_done_reg;

  // The first pixel of a frame uses the live mode input; it is latched for the rest.
  assign first_pix = (row_reg == '0) && (col_reg == '0);
  assign mode_eff  = first_pix ? mode : mode_reg;

  // Window-fire decision, last-result detection and line-buffer write address.
  always_comb begin
    int r;
    int c;
    r        = int'(row_reg);
    c        = int'(col_reg);
    fire     = (r >= POOL_SIZE - 1) && (c >= POOL_SIZE - 1) &&
               (((r - POOL_SIZE + 1) % POOL_STRIDE) == 0) &&
               (((c - POOL_SIZE + 1) % POOL_STRIDE) == 0);
    last_pos = (r == LAST_ROW) && (c == LAST_COL);
    wr_addr  = ADDR_W'((r % POOL_SIZE) * IMG_WIDTH + c);
  end

  // Gather the window: bottom-right sample is the live pixel, the rest come
  // from the line buffer (row r lives in slot r mod POOL_SIZE).
  always_comb begin
    int rr;
    int cc;
    rr = 0;
    cc = 0;
    for (int k = 0; k < WIN; k++) begin
      rr = (int'(row_reg) + 1 + k / POOL_SIZE) % POOL_SIZE;
      cc = int'(col_reg) + 1 + (k % POOL_SIZE) - POOL_SIZE;
      if (cc < 0) cc = 0;
      if (k == WIN - 1) win[k] = in_data;
      else              win[k] = line_mem[ADDR_W'(rr * IMG_WIDTH + cc)];
    end
  end

  // Per-lane signed max and floor-average over the window.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [SUM_W-1:0]      sum_val;
    logic signed [SUM_W-1:0]      avg_val;

    // Reduce the window samples of this lane.
    always_comb begin
      logic signed [DATA_WIDTH-1:0] s;
      s       = '0;
      max_val = win[0][gi*DATA_WIDTH +: DATA_WIDTH];
      sum_val = '0;
      for (int k = 0; k < WIN; k++) begin
        s       = win[k][gi*DATA_WIDTH +: DATA_WIDTH];
        sum_val = sum_val + SUM_W'(s);
        if (s > max_val) max_val = s;
      end
      avg_val = sum_val >>> SHIFT;
    end

    assign result[gi*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? avg_val[DATA_WIDTH-1:0] : max_val;
  end

  // Raster counters and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      mode_reg <= 1'b0;
    end else if (accept) begin
      if (first_pix) mode_reg <= mode;
      if (col_reg == COL_W'(IMG_WIDTH - 1)) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Line buffer write; contents are always overwritten before they are read.
  always_ff @(posedge clk) begin
    if (accept) line_mem[wr_addr] <= in_data;
  end

  // Output register: a new result wins over draining the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= out_valid_reg && out_ready && out_last_reg;
      if (accept && fire) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result;
        out_last_reg  <= last_pos;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pool_stream.md
Name: pool_stream

Overview:
- Streaming, multi-channel 2-D pooling engine for the CNN datapath. It sits between the convolution/activation stage and the next layer.
- Takes a raster-order pixel stream (all channels in parallel, one pixel per accepted beat), buffers POOL_SIZE rows internally, and emits pooled results in raster order over a valid/ready handshake.
- Runtime-selectable max or average pooling; signed arithmetic throughout.

Parameters:
- DATA_WIDTH, 16: signed sample width per channel.
- CHANNELS, 4: channels processed in parallel, one lane each.
- IMG_WIDTH, 3: input feature-map columns.
- IMG_HEIGHT, 3: input feature-map rows.
- POOL_SIZE, 2: square window edge; must be 1, 2 or 4.
- POOL_STRIDE, 1: window step in both dimensions, >=1.
- OUT_WIDTH, derived: (IMG_WIDTH-POOL_SIZE)/POOL_STRIDE+1.
- OUT_HEIGHT, derived: (IMG_HEIGHT-POOL_SIZE)/POOL_STRIDE+1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = max, 1 = average; sampled on the first accepted pixel of each frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  CHANNELS*DATA_WIDTH  packed signed pixel; lane c = bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  CHANNELS*DATA_WIDTH  packed signed pooled result, same lane packing as in_data.
- out_last  out  1  high with the final result of a frame.
- frame_done  out  1  one-cycle pulse when the final result of a frame is accepted.

Behaviour:
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a single output register; there are no bubbles under continuous flow.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, advancing on each accepted pixel.
  - col wraps to 0 and row increments at col = IMG_WIDTH-1.
  - After the pixel at row = IMG_HEIGHT-1, col = IMG_WIDTH-1, both return to 0 and the next frame starts.
- Storage:
  - Line buffer of POOL_SIZE rows x IMG_WIDTH pixels x CHANNELS, written at [row mod POOL_SIZE][col].
  - The window is evaluated on the cycle a pixel is accepted, using the stored rows plus the current pixel.
- Window fire: the accepted pixel triggers a result when all of the following hold:
  - row >= POOL_SIZE-1 and col >= POOL_SIZE-1;
  - (row-POOL_SIZE+1) mod POOL_STRIDE = 0;
  - (col-POOL_SIZE+1) mod POOL_STRIDE = 0.
  - Pixels not covered by any window (stride remainder) are accepted and discarded.
- Latency: out_valid rises 1 cycle after the accepting edge of the triggering pixel.
- Max mode: signed comparison per lane; result is the largest of the POOL_SIZE^2 samples.
- Average mode:
  - Per-lane signed sum, DATA_WIDTH + 2*log2(POOL_SIZE) bits, no overflow.
  - Result = sum arithmetic-shifted right by 2*log2(POOL_SIZE), i.e. floor toward -inf, truncated to DATA_WIDTH.
  - POOL_SIZE = 1 passes samples through.
- Mode latch: mode is captured on the accepted pixel with row = 0, col = 0 and held for the whole frame. Changes mid-frame are ignored.
- out_last is asserted with the result at output position (OUT_HEIGHT-1, OUT_WIDTH-1).
- frame_done pulses on the cycle after the out_last transfer.
- Reset (including mid-frame or with a pending result):
  - out_valid = 0, out_data = 0, out_last = 0, frame_done = 0.
  - row = col = 0; latched mode = 0 (max).
  - in_ready = 1 on the first cycle after rst deasserts.
  - Line-buffer contents need no clearing; they are fully overwritten before first use.
- Simultaneous events: an output transfer and a new firing input in the same cycle load the new result; out_valid stays 1.

Test Plan:
- Defaults, mode = 0, one channel lane, pixels 1..9 streamed, out_ready = 1 -> outputs 5, 6, 8, 9; out_last on 9; frame_done one cycle after.
- Same stream, mode = 1 -> outputs 3, 4, 6, 7 (sums 12, 16, 24, 28 >>> 2).
- Negative data: lane 0 = -1, -2, -3, -4, -5, -6, -7, -8, -9 with mode = 0 -> -1, -2, -4, -5. With mode = 1 -> -3, -4, -6, -7 (sum -12 >>> 2 = -3). A window {-1, 0, 0, 0} in average mode -> -1.
- Backpressure: out_ready low for 5 cycles after the first result -> in_ready = 0, out_data held at 5, no pixel lost; final sequence unchanged. Independent lane values per channel are checked simultaneously.
- IMG 4x4, POOL_SIZE = 2, POOL_STRIDE = 2, pixels 1..16, mode = 0 -> 6, 8, 14, 16. Then a second back-to-back frame in mode = 1 -> 3, 5, 11, 13.
- rst asserted after 5 pixels, then a fresh 1..9 frame -> outputs 5, 6, 8, 9, with no stale result emitted.
